// File: rtl/reg_wr_pkg.sv
// Shared constants and request bundle for the register-file write port.
// Optional feature macro: XZR_DISCARD_EN (writes to the top register are dropped).
package reg_wr_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/decoder_onehot.sv
// Address to one-hot decoder; all-zero output when en is low.
// Ports: addr (ADDR_W), en (1) -> onehot (NREG).
module decoder_onehot
   import reg_wr_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output logic [NREG-1:0]   onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_wr_port.sv
// Register-file write port: in-order pending-write queue, one-hot write
// enables from the head, and a youngest-match forwarding lookup.
// Ports: clk, reset_n (async low); in_valid/in_ready/in_addr/in_data push side;
// stall, wr_en, wr_data write side; q_addr/q_hit/q_data lookup; count.
// Optional feature macro: XZR_DISCARD_EN (register NREG-1 writes are dropped).
module reg_wr_port
   import reg_wr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       stall,
   output logic [NREG-1:0]            wr_en,
   output logic [DATA_W-1:0]          wr_data,
   input  logic [ADDR_W-1:0]          q_addr,
   output logic                       q_hit,
   output logic [DATA_W-1:0]          q_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wr_req_t         mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   cnt;
   logic            alive;
   logic            acc;
   logic            push;
   logic            pop;
   logic            top_in;
   logic [NREG-1:0] dec;
   logic            hit;
   logic [DATA_W-1:0] hit_data;
   logic [PW-1:0]   idx;
   int              s;
   wr_req_t         req;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // alive holds in_ready low until the first edge after reset release
   assign count    = cnt;
   assign in_ready = alive && (cnt < CW'(DEPTH));
   assign acc      = in_valid & in_ready;
   assign pop      = (cnt != '0) & ~stall;
   assign req.addr = in_addr;
   assign req.data = in_data;

`ifdef XZR_DISCARD_EN
   assign top_in = (in_addr == ADDR_W'(NREG - 1));
`else
   assign top_in = 1'b0;
`endif

   assign push = acc & ~top_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         alive <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         alive <= 1'b1;
         if (push) begin
            mem[tail] <= req;
            tail      <= nxt(tail);
         end
         if (pop) begin
            head <= nxt(head);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   decoder_onehot u_dec (
      .addr   (mem[head].addr),
      .en     (pop),
      .onehot (dec)
   );

`ifdef XZR_DISCARD_EN
   assign wr_en = {1'b0, dec[NREG-2:0]};
`else
   assign wr_en = dec;
`endif

   assign wr_data = pop ? mem[head].data : '0;

   // Walk oldest to youngest so the last match found is the newest write
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      s        = 0;
      for (int i = 0; i < DEPTH; i++) begin
         s = int'(head) + i;
         if (s >= DEPTH) begin
            s = s - DEPTH;
         end
         idx = PW'(s);
         if ((i < int'(cnt)) && (mem[idx].addr == q_addr)) begin
            hit      = 1'b1;
            hit_data = mem[idx].data;
         end
      end
   end

`ifdef XZR_DISCARD_EN
   assign q_hit  = hit && (q_addr != ADDR_W'(NREG - 1));
   assign q_data = q_hit ? hit_data : '0;
`else
   assign q_hit  = hit;
   assign q_data = hit_data;
`endif

endmodule

// File: tb/tb_reg_wr_port.sv
// Self-checking bench for reg_wr_port: queue-based model, per-cycle compare.
// Honors XZR_DISCARD_EN when defined at build time.
module tb_reg_wr_port;
   import reg_wr_pkg::*;

   localparam int DEPTH = 2;
`ifdef XZR_DISCARD_EN
   localparam bit XZR = 1'b1;
   localparam logic [31:0] EXP5_WR  = 32'h0000_0000;
   localparam int          EXP5_CNT = 0;
`else
   localparam bit XZR = 1'b0;
   localparam logic [31:0] EXP5_WR  = 32'h8000_0000;
   localparam int          EXP5_CNT = 1;
`endif

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              stall;
   logic [NREG-1:0]   wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] q_addr;
   logic              q_hit;
   logic [DATA_W-1:0] q_data;
   logic [1:0]        count;

   int n_chk = 0;
   int n_fail = 0;

   reg_wr_port #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .stall    (stall),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .q_addr   (q_addr),
      .q_hit    (q_hit),
      .q_data   (q_data),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending writes
   wr_req_t mq[$];
   bit      m_alive = 1'b0;
   bit      m_pop;
   bit      m_acc;
   wr_req_t m_req;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_alive = 1'b0;
      end else begin
         m_pop = (mq.size() > 0) && !stall;
         m_acc = m_alive && in_valid && (mq.size() < DEPTH);
         if (m_pop) void'(mq.pop_front());
         if (m_acc && !(XZR && in_addr == ADDR_W'(NREG - 1))) begin
            m_req.addr = in_addr;
            m_req.data = in_data;
            mq.push_back(m_req);
         end
         m_alive = 1'b1;
      end
   end

   bit              cmp_en = 1'b0;
   logic [31:0]     e_wr;
   logic [63:0]     e_wd;
   bit              e_hit;
   logic [63:0]     e_qd;

   always @(negedge clk) begin
      if (cmp_en) begin
         e_wr  = '0;
         e_wd  = '0;
         e_hit = 1'b0;
         e_qd  = '0;
         if (mq.size() > 0 && !stall) begin
            e_wr = 32'(1) << mq[0].addr;
            e_wd = mq[0].data;
         end
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!e_hit && mq[i].addr == q_addr) begin
               e_hit = 1'b1;
               e_qd  = mq[i].data;
            end
         end
         chk("m_count", count, 64'(mq.size()));
         chk("m_in_ready", in_ready,
             m_alive && (mq.size() < DEPTH));
         chk("m_wr_en", wr_en, e_wr);
         chk("m_wr_data", wr_data, e_wd);
         chk("m_q_hit", q_hit, e_hit);
         chk("m_q_data", q_data, e_qd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [4:0] a,
                        input logic [63:0] d);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b1;
      stall    = 1'b0;
      q_addr   = '0;
      drive(1'b1, 5'd0, 64'h0);
      #1 reset_n = 1'b0;
      cmp_en = 1'b1;

      // reset state
      smp();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_count", count, 0);
      #2 reset_n = 1'b1;
      cyc();
      in_valid = 1'b0;
      smp();
      chk("rel_in_ready", in_ready, 1);

      // single write, one cycle latency
      cyc();
      drive(1'b1, 5'd5, 64'hDEAD);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("t2_wr_en", wr_en, 32'h0000_0020);
      chk("t2_wr_data", wr_data, 64'hDEAD);
      cyc();
      smp();
      chk("t2_count", count, 0);

      // fill under stall, then drain with a held third request
      cyc();
      stall = 1'b1;
      drive(1'b1, 5'd1, 64'h1);
      cyc();
      drive(1'b1, 5'd2, 64'h2);
      cyc();
      drive(1'b1, 5'd3, 64'h3);
      smp();
      chk("t3_count_full", count, 2);
      chk("t3_in_ready", in_ready, 0);
      cyc();
      stall = 1'b0;
      smp();
      chk("t3_wr_en_1", wr_en, 32'h2);
      cyc();
      smp();
      chk("t3_wr_en_2", wr_en, 32'h4);
      chk("t3_ready_again", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("t3_wr_en_3", wr_en, 32'h8);
      chk("t3_count_1", count, 1);
      cyc();
      smp();
      chk("t3_empty", count, 0);

      // forwarding: youngest match wins
      cyc();
      stall = 1'b1;
      drive(1'b1, 5'd7, 64'hAAAA);
      cyc();
      drive(1'b1, 5'd7, 64'hBBBB);
      cyc();
      in_valid = 1'b0;
      q_addr   = 5'd7;
      #1;
      chk("t4_hit7", q_hit, 1);
      chk("t4_data7", q_data, 64'hBBBB);
      q_addr = 5'd8;
      #1;
      chk("t4_hit8", q_hit, 0);
      chk("t4_data8", q_data, 0);
      stall = 1'b0;
      cyc();
      cyc();
      smp();
      chk("t4_empty", count, 0);

      // top register
      cyc();
      drive(1'b1, 5'd31, 64'h5555);
      smp();
      chk("t5_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("t5_wr_en", wr_en, EXP5_WR);
      chk("t5_count", count, EXP5_CNT);
      cyc();
      smp();
      chk("t5_empty", count, 0);

      // reset mid-operation discards pending writes
      cyc();
      stall = 1'b1;
      drive(1'b1, 5'd9, 64'h9);
      cyc();
      drive(1'b1, 5'd10, 64'hA);
      cyc();
      in_valid = 1'b0;
      smp();
      chk("t6_full", count, 2);
      cyc();
      #1 reset_n = 1'b0;
      #1;
      chk("t6_count_rst", count, 0);
      chk("t6_ready_rst", in_ready, 0);
      stall = 1'b0;
      smp();
      #2 reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         smp();
         chk("t6_no_wr", wr_en, 0);
      end

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cyc();
         case ($urandom_range(0, 3))
            0: in_addr = 5'd7;
            1: in_addr = 5'd31;
            default: in_addr = 5'($urandom);
         endcase
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = {$urandom, $urandom};
         stall    = ($urandom_range(0, 2) == 0);
         q_addr   = ($urandom_range(0, 1) == 0) ? 5'd7 : in_addr;
         if ($urandom_range(0, 199) == 0) begin
            #1 reset_n = 1'b0;
            smp();
            #2 reset_n = 1'b1;
         end
      end

      cyc();
      smp();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
